adc_serial_reader: RTL and testbench

- Drives a multi-channel serial SAR ADC and emits one signed sample per channel as a data/data_valid word stream, with channel tag, for the oversample filters.
- Sequence per frame: convert-start, wait for busy, shift frame MSB-first, emit each word as it completes.
- Sits between the ADC pins and the per-channel oversample filter instances.

---
 rtl/adc_serial_reader_pkg.sv | 24 ++
 rtl/adc_serial_reader_sync_2ff.sv | 25 ++
 rtl/adc_serial_reader.sv | 147 ++++++++++++++
 tb/tb_adc_serial_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_serial_reader_pkg.sv
// Shared types and defaults for the serial SAR ADC reader and the oversample filters downstream.
// Keep the channel and word defaults in step with the oversample_filter instantiations.
package adc_serial_reader_pkg;

    localparam int ADC_N_CHAN = 8;
    localparam int ADC_W_DATA = 18;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_CONVST,
        ST_BUSY_HI,
        ST_BUSY_LO,
        ST_READ,
        ST_DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/adc_serial_reader_sync_2ff.sv
// Two-flop synchronizer for the asynchronous ADC pins.
// The output stays low while reset is asserted.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_serial_reader.sv
// Serial SAR ADC frame reader: convert-start, busy handshake, MSB-first shift-in,
// and one tagged signed word strobe per channel.
module adc_serial_reader
    import adc_serial_reader_pkg::*;
#(
    parameter int N_CHAN   = ADC_N_CHAN,
    parameter int W_DATA   = ADC_W_DATA,
    parameter int W_CHAN   = 3,
    parameter int SCLK_DIV = 2,
    parameter int T_CONVST = 4,
    parameter int T_RESET  = 16,
    parameter int BUSY_TMO = 4096
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              run_in,
    input  logic              adc_busy_in,
    input  logic              adc_dout_in,
    output logic              adc_reset_out,
    output logic              adc_convst_out,
    output logic              adc_cs_out,
    output logic              adc_sclk_out,
    output logic [W_DATA-1:0] data_out,
    output logic [W_CHAN-1:0] chan_out,
    output logic              data_valid_out,
    output logic              timeout_out
);

    localparam int CNT_W = $clog2(max3(BUSY_TMO, T_RESET, T_CONVST)) + 1;
    localparam int DIV_W = $clog2(SCLK_DIV) + 1;
    localparam int BIT_W = $clog2(W_DATA) + 1;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [W_CHAN-1:0] chan_idx;
    logic [W_DATA-2:0] shift_q;
    logic [W_DATA-1:0] word_shift;
    logic              busy_s;
    logic              dout_s;
    logic              sclk_edge;
    logic              rise_edge;
    logic              word_end;
    logic              frame_end;
    logic              tmo_hit;
    logic              timeout_set;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .d        ({adc_busy_in, adc_dout_in}),
        .q        ({busy_s, dout_s})
    );

    // The synchronized bit seen on a rising SCLK edge left the pin two clocks earlier,
    // while SCLK was still low, so it is the bit the ADC presented for this edge.
    assign word_shift = {shift_q, dout_s};

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        sclk_edge   = (state == ST_READ) && (div_cnt == DIV_W'(SCLK_DIV - 1));
        rise_edge   = sclk_edge && !adc_sclk_out;
        word_end    = rise_edge && (bit_idx == BIT_W'(W_DATA - 1));
        frame_end   = word_end && (chan_idx == W_CHAN'(N_CHAN - 1));
        tmo_hit     = (cnt == CNT_W'(BUSY_TMO - 1));
        state_next  = state;

        case (state)
            ST_RESET:   if (cnt == CNT_W'(T_RESET - 1)) state_next = ST_IDLE;
            ST_IDLE:    if (run_in) state_next = ST_CONVST;
            ST_CONVST:  if (cnt == CNT_W'(T_CONVST - 1)) state_next = ST_BUSY_HI;
            ST_BUSY_HI: begin
                if (busy_s)       state_next = ST_BUSY_LO;
                else if (tmo_hit) state_next = ST_RESET;
            end
            ST_BUSY_LO: begin
                if (!busy_s)      state_next = ST_READ;
                else if (tmo_hit) state_next = ST_RESET;
            end
            ST_READ:    if (frame_end) state_next = ST_DONE;
            ST_DONE:    state_next = run_in ? ST_CONVST : ST_IDLE;
            default:    state_next = ST_RESET;
        endcase

        timeout_set = ((state == ST_BUSY_HI) || (state == ST_BUSY_LO)) && (state_next == ST_RESET);
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state <= ST_RESET;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state_next != state) ? '0 : cnt + 1'b1;
        end
    end

    // Pin controls are registered from the current state, so each lags the state by one clock.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            adc_reset_out  <= 1'b0;
            adc_convst_out <= 1'b1;
            adc_cs_out     <= 1'b1;
            adc_sclk_out   <= 1'b1;
            div_cnt        <= '0;
            bit_idx        <= '0;
            chan_idx       <= '0;
            shift_q        <= '0;
            data_out       <= '0;
            chan_out       <= '0;
            data_valid_out <= 1'b0;
            timeout_out    <= 1'b0;
        end else begin
            adc_reset_out  <= (state == ST_RESET);
            adc_convst_out <= (state != ST_CONVST);
            adc_cs_out     <= (state != ST_READ);
            data_valid_out <= word_end;
            if (timeout_set) timeout_out <= 1'b1;

            if (state != ST_READ) begin
                adc_sclk_out <= 1'b1;
                div_cnt      <= '0;
                bit_idx      <= '0;
                chan_idx     <= '0;
            end else if (sclk_edge) begin
                adc_sclk_out <= ~adc_sclk_out;
                div_cnt      <= '0;
                if (rise_edge) begin
                    shift_q <= word_shift[W_DATA-2:0];
                    if (word_end) begin
                        data_out <= word_shift;
                        chan_out <= chan_idx;
                        bit_idx  <= '0;
                        chan_idx <= frame_end ? '0 : chan_idx + 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_reader.sv
// Self-checking bench for adc_serial_reader with a behavioural two-channel ADC model.
// Frames are table-driven; timeout and mid-read reset are hand-written sequences.
module tb_adc_serial_reader;

    localparam int N_CHAN    = 2;
    localparam int W_DATA    = 18;
    localparam int W_CHAN    = 1;
    localparam int SCLK_DIV  = 2;
    localparam int T_CONVST  = 4;
    localparam int T_RESET   = 16;
    localparam int BUSY_TMO  = 64;
    localparam int BUSY_CLKS = 50;
    localparam int NF        = 4;

    logic              clk_in      = 1'b0;
    logic              reset_in    = 1'b1;
    logic              run_in      = 1'b0;
    logic              adc_busy_in = 1'b0;
    logic              adc_dout_in = 1'b0;
    logic              adc_reset_out;
    logic              adc_convst_out;
    logic              adc_cs_out;
    logic              adc_sclk_out;
    logic [W_DATA-1:0] data_out;
    logic [W_CHAN-1:0] chan_out;
    logic              data_valid_out;
    logic              timeout_out;

    adc_serial_reader #(
        .N_CHAN   (N_CHAN),
        .W_DATA   (W_DATA),
        .W_CHAN   (W_CHAN),
        .SCLK_DIV (SCLK_DIV),
        .T_CONVST (T_CONVST),
        .T_RESET  (T_RESET),
        .BUSY_TMO (BUSY_TMO)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .run_in         (run_in),
        .adc_busy_in    (adc_busy_in),
        .adc_dout_in    (adc_dout_in),
        .adc_reset_out  (adc_reset_out),
        .adc_convst_out (adc_convst_out),
        .adc_cs_out     (adc_cs_out),
        .adc_sclk_out   (adc_sclk_out),
        .data_out       (data_out),
        .chan_out       (chan_out),
        .data_valid_out (data_valid_out),
        .timeout_out    (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic signed [63:0] actual,
                         input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // ADC model: busy pulse after convst release, frame shifted MSB-first,
    // MSB presented on CS fall, next bit presented after each SCLK rise.
    logic                     busy_en = 1'b1;
    logic [W_DATA-1:0]        word_q[$];
    logic [W_DATA-1:0]        model_word;
    logic [N_CHAN*W_DATA-1:0] frame_bits = '0;
    int                       bit_pos = 0;

    always @(posedge adc_convst_out) begin
        if (busy_en && !reset_in) begin
            @(negedge clk_in);
            adc_busy_in = 1'b1;
            repeat (BUSY_CLKS) @(negedge clk_in);
            adc_busy_in = 1'b0;
        end
    end

    always @(negedge adc_cs_out) begin
        if (!reset_in) begin
            for (int c = 0; c < N_CHAN; c++) begin
                model_word = (word_q.size() > 0) ? word_q.pop_front() : '0;
                frame_bits = (frame_bits << W_DATA) | {{(N_CHAN*W_DATA-W_DATA){1'b0}}, model_word};
            end
            bit_pos     = 0;
            adc_dout_in = frame_bits[N_CHAN*W_DATA-1];
        end
    end

    always @(posedge adc_sclk_out) begin
        if (!adc_cs_out && !reset_in) begin
            bit_pos++;
            if (bit_pos < N_CHAN*W_DATA) adc_dout_in = frame_bits[N_CHAN*W_DATA-1-bit_pos];
        end
    end

    // Monitors
    int sclk_rises      = 0;
    int cs_falls        = 0;
    int convst_falls    = 0;
    int convst_low_clks = 0;
    int got_data[$];
    int got_chan[$];

    always @(posedge adc_sclk_out)  if (!reset_in) sclk_rises++;
    always @(negedge adc_cs_out)    if (!reset_in) cs_falls++;
    always @(negedge adc_convst_out) if (!reset_in) convst_falls++;

    always @(negedge clk_in) begin
        if (!reset_in && !adc_convst_out) convst_low_clks++;
        if (data_valid_out) begin
            got_data.push_back(int'($signed(data_out)));
            got_chan.push_back(int'(chan_out));
        end
    end

    task automatic measure_reset_pulse(output int len);
        int n;
        n   = 0;
        len = 0;
        while (!adc_reset_out && n < 500) begin @(negedge clk_in); n++; end
        while (adc_reset_out && len < 500) begin @(negedge clk_in); len++; end
    endtask

    typedef struct {
        logic [W_DATA-1:0] w0;
        logic [W_DATA-1:0] w1;
        int                exp0;
        int                exp1;
    } frame_vec_t;

    frame_vec_t tbl[NF];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int len;
        int base_rises;
        int base_csf;
        int base_cf;
        int base_cl;

        tbl[0] = '{18'h2ABCD, 18'h1FFFF, -87091, 131071};
        tbl[1] = '{18'h00001, 18'h3FFFF, 1, -1};
        tbl[2] = '{18'h20000, 18'h00000, -131072, 0};
        tbl[3] = '{18'h15555, 18'h0AAAA, 87381, 43690};

        // Reset values, then the power-up ADC reset pulse with run_in low
        repeat (3) @(negedge clk_in);
        check("rst_adc_reset", adc_reset_out, 0);
        check("rst_convst", adc_convst_out, 1);
        check("rst_cs", adc_cs_out, 1);
        check("rst_sclk", adc_sclk_out, 1);
        check("rst_data", data_out, 0);
        check("rst_chan", chan_out, 0);
        check("rst_valid", data_valid_out, 0);
        check("rst_timeout", timeout_out, 0);
        reset_in = 1'b0;
        measure_reset_pulse(len);
        check("por_reset_len", len, T_RESET);
        repeat (50) @(negedge clk_in);
        check("idle_convst_falls", convst_falls, 0);
        check("idle_valids", got_data.size(), 0);
        check("idle_cs", adc_cs_out, 1);
        check("idle_sclk", adc_sclk_out, 1);

        // Table-driven back-to-back frames; run_in drops during READ of the last frame
        base_rises = sclk_rises;
        base_csf   = cs_falls;
        base_cf    = convst_falls;
        base_cl    = convst_low_clks;
        for (int i = 0; i < NF; i++) begin
            word_q.push_back(tbl[i].w0);
            word_q.push_back(tbl[i].w1);
        end
        run_in = 1'b1;
        n = 0;
        while (cs_falls - base_csf < NF && n < NF*2000) begin @(negedge clk_in); n++; end
        run_in = 1'b0;
        n = 0;
        while (got_data.size() < 2*NF && n < 2000) begin @(negedge clk_in); n++; end
        check("tbl_word_count", got_data.size(), 2*NF);
        for (int i = 0; i < NF; i++) begin
            check($sformatf("tbl%0d_w0_data", i), got_data[2*i], tbl[i].exp0);
            check($sformatf("tbl%0d_w0_chan", i), got_chan[2*i], 0);
            check($sformatf("tbl%0d_w1_data", i), got_data[2*i+1], tbl[i].exp1);
            check($sformatf("tbl%0d_w1_chan", i), got_chan[2*i+1], 1);
        end
        repeat (200) @(negedge clk_in);
        check("tbl_cs_after", adc_cs_out, 1);
        check("tbl_convst_after", adc_convst_out, 1);
        check("tbl_convst_count", convst_falls - base_cf, NF);
        check("tbl_convst_low_clks", convst_low_clks - base_cl, NF*T_CONVST);
        check("tbl_sclk_rises", sclk_rises - base_rises, NF*N_CHAN*W_DATA);
        check("tbl_no_extra_words", got_data.size(), 2*NF);

        // Busy never asserts: timeout, ADC reset pulse, no words
        busy_en = 1'b0;
        got_data.delete();
        got_chan.delete();
        run_in = 1'b1;
        n = 0;
        while (adc_convst_out && n < 500) begin @(negedge clk_in); n++; end
        while (!adc_convst_out && n < 500) begin @(negedge clk_in); n++; end
        n = 0;
        while (!timeout_out && n < 500) begin @(negedge clk_in); n++; end
        run_in = 1'b0;
        check("tmo_set", timeout_out, 1);
        check_range("tmo_latency", n, BUSY_TMO - 4, BUSY_TMO + 4);
        measure_reset_pulse(len);
        check("tmo_reset_len", len, T_RESET);
        repeat (50) @(negedge clk_in);
        check("tmo_sticky", timeout_out, 1);
        check("tmo_no_words", got_data.size(), 0);

        // Reset asserted mid-READ, then a clean frame
        busy_en = 1'b1;
        word_q.delete();
        word_q.push_back(18'h12345);
        word_q.push_back(18'h0F0F0);
        base_rises = sclk_rises;
        run_in = 1'b1;
        n = 0;
        while (sclk_rises - base_rises < 10 && n < 2000) begin @(negedge clk_in); n++; end
        check("mid_cs_low", adc_cs_out, 0);
        check("mid_pre_data", data_out, 43690);
        check("mid_pre_chan", chan_out, 1);
        #2 reset_in = 1'b1;
        #1;
        check("mid_rst_cs", adc_cs_out, 1);
        check("mid_rst_sclk", adc_sclk_out, 1);
        check("mid_rst_convst", adc_convst_out, 1);
        check("mid_rst_adc_reset", adc_reset_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_chan", chan_out, 0);
        check("mid_rst_valid", data_valid_out, 0);
        check("mid_rst_timeout", timeout_out, 0);
        word_q.delete();
        word_q.push_back(18'h3FFFF);
        word_q.push_back(18'h00001);
        repeat (3) @(negedge clk_in);
        check("mid_no_partial", got_data.size(), 0);
        base_csf = cs_falls;
        reset_in = 1'b0;
        n = 0;
        while (cs_falls == base_csf && n < 2000) begin @(negedge clk_in); n++; end
        run_in = 1'b0;
        n = 0;
        while (got_data.size() < 2 && n < 2000) begin @(negedge clk_in); n++; end
        repeat (20) @(negedge clk_in);
        check("post_word_count", got_data.size(), 2);
        check("post_w0_data", got_data[0], -1);
        check("post_w0_chan", got_chan[0], 0);
        check("post_w1_data", got_data[1], 1);
        check("post_w1_chan", got_chan[1], 1);
        check("post_cs", adc_cs_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
